// File: rtl/state_machine.sv
// BIST sequencer: IDLE -> INIT -> RUN -> FINISH -> DONE with registered phase outputs.
// Optional abort of INIT/RUN on bist_start drop is enabled by defining BIST_ABORT_EN.
module state_machine #(
  parameter int INIT_CYCLES = 2,
  parameter int RUN_CYCLES  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic bist_start,
  output logic mode,
  output logic bist_end,
  output logic init,
  output logic running,
  output logic finish
);

  localparam int MAX_CYCLES = (INIT_CYCLES > RUN_CYCLES) ? INIT_CYCLES : RUN_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Outputs are registered from the next state, so they line up with the
  // first cycle of each state exactly as a Moore decode of state would.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode     <= 1'b0;
      bist_end <= 1'b0;
      init     <= 1'b0;
      running  <= 1'b0;
      finish   <= 1'b0;
    end else begin
      mode     <= 1'b0;
      bist_end <= 1'b0;
      init     <= 1'b0;
      running  <= 1'b0;
      finish   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bist_start) begin
            state <= ST_INIT;
            mode  <= 1'b1;
            init  <= 1'b1;
          end
        end
        ST_INIT: begin
`ifdef BIST_ABORT_EN
          if (!bist_start) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else
`endif
          if (cnt == INIT_LAST) begin
            state   <= ST_RUN;
            cnt     <= '0;
            mode    <= 1'b1;
            running <= 1'b1;
          end else begin
            cnt  <= cnt + CW'(1);
            mode <= 1'b1;
            init <= 1'b1;
          end
        end
        ST_RUN: begin
`ifdef BIST_ABORT_EN
          if (!bist_start) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else
`endif
          if (cnt == RUN_LAST) begin
            state  <= ST_FINISH;
            cnt    <= '0;
            mode   <= 1'b1;
            finish <= 1'b1;
          end else begin
            cnt     <= cnt + CW'(1);
            mode    <= 1'b1;
            running <= 1'b1;
          end
        end
        ST_FINISH: begin
          state    <= ST_DONE;
          cnt      <= '0;
          bist_end <= 1'b1;
        end
        ST_DONE: begin
          cnt <= '0;
          if (!bist_start) begin
            state <= ST_IDLE;
          end else begin
            bist_end <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: reset, nominal run, release, mid-test reset,
// abort (behaviour depends on BIST_ABORT_EN) and a 1/1 parameter instance.
module tb_state_machine;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic bist_start  = 1'b0;
  logic bist_start2 = 1'b0;

  logic mode, bist_end, init, running, finish;
  logic mode2, bist_end2, init2, running2, finish2;

  int vectors    = 0;
  int miscompares = 0;

  // {mode, bist_end, init, running, finish}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_INIT = 5'b10100;
  localparam logic [4:0] O_RUN  = 5'b10010;
  localparam logic [4:0] O_FIN  = 5'b10001;
  localparam logic [4:0] O_DONE = 5'b01000;

  logic [4:0] obs, obs2;
  assign obs  = {mode, bist_end, init, running, finish};
  assign obs2 = {mode2, bist_end2, init2, running2, finish2};

  state_machine #(.INIT_CYCLES(2), .RUN_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .bist_start(bist_start),
    .mode(mode), .bist_end(bist_end), .init(init),
    .running(running), .finish(finish)
  );

  state_machine #(.INIT_CYCLES(1), .RUN_CYCLES(1)) dut2 (
    .clock(clock), .reset(reset), .bist_start(bist_start2),
    .mode(mode2), .bist_end(bist_end2), .init(init2),
    .running(running2), .finish(finish2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bist_start = 1'b1;
    bist_start2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== O_IDLE) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, O_IDLE);
      end
      vectors++;
      if (obs2 !== O_IDLE) begin
        miscompares++;
        $display("FAIL reset_hold2[%0d]: got %b expected %b", i, obs2, O_IDLE);
      end
    end
    reset = 1'b1;
    bist_start2 = 1'b0;
    tick();
    vectors++;
    if (obs !== O_INIT) begin
      miscompares++;
      $display("FAIL reset_first_edge: got %b expected %b", obs, O_INIT);
    end
    reset = 1'b0;
    bist_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== O_IDLE || obs2 !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_idle: got %b/%b expected %b", obs, obs2, O_IDLE);
    end
  endtask

  task automatic test_nominal();
    logic [4:0] exp;
    int mode_cnt = 0;
    bist_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c < 2)       exp = O_INIT;
      else if (c < 6)  exp = O_RUN;
      else if (c == 6) exp = O_FIN;
      else             exp = O_DONE;
      if (mode === 1'b1) mode_cnt++;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL nominal[%0d]: got %b expected %b", c, obs, exp);
      end
    end
    vectors++;
    if (mode_cnt != 7) begin
      miscompares++;
      $display("FAIL nominal_mode_len: got %0d expected 7", mode_cnt);
    end
  endtask

  task automatic test_release();
    bist_start = 1'b0;
    tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL release_idle: got %b expected %b", obs, O_IDLE);
    end
    tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL release_stay: got %b expected %b", obs, O_IDLE);
    end
    bist_start = 1'b1;
    tick();
    vectors++;
    if (obs !== O_INIT) begin
      miscompares++;
      $display("FAIL restart_init: got %b expected %b", obs, O_INIT);
    end
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (obs !== O_DONE) begin
      miscompares++;
      $display("FAIL restart_done: got %b expected %b", obs, O_DONE);
    end
    bist_start = 1'b0;
    tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL restart_release: got %b expected %b", obs, O_IDLE);
    end
  endtask

  task automatic test_mid_reset();
    bist_start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (obs !== O_RUN) begin
      miscompares++;
      $display("FAIL midreset_pre: got %b expected %b", obs, O_RUN);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL midreset_clear: got %b expected %b", obs, O_IDLE);
    end
    reset = 1'b1;
    bist_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (obs !== O_IDLE) begin
        miscompares++;
        $display("FAIL midreset_quiet[%0d]: got %b expected %b", i, obs, O_IDLE);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp;
    bist_start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (obs !== O_RUN) begin
      miscompares++;
      $display("FAIL abort_pre: got %b expected %b", obs, O_RUN);
    end
    bist_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
`ifdef BIST_ABORT_EN
      exp = O_IDLE;
`else
      if (c < 3)       exp = O_RUN;
      else if (c == 3) exp = O_FIN;
      else if (c == 4) exp = O_DONE;
      else             exp = O_IDLE;
`endif
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL abort[%0d]: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [4:0] exp;
    int mode_cnt = 0;
    bist_start2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0)      exp = O_INIT;
      else if (c == 1) exp = O_RUN;
      else if (c == 2) exp = O_FIN;
      else             exp = O_DONE;
      if (mode2 === 1'b1) mode_cnt++;
      vectors++;
      if (obs2 !== exp) begin
        miscompares++;
        $display("FAIL sweep[%0d]: got %b expected %b", c, obs2, exp);
      end
    end
    vectors++;
    if (mode_cnt != 3) begin
      miscompares++;
      $display("FAIL sweep_mode_len: got %0d expected 3", mode_cnt);
    end
    bist_start2 = 1'b0;
    tick();
    vectors++;
    if (obs2 !== O_IDLE) begin
      miscompares++;
      $display("FAIL sweep_release: got %b expected %b", obs2, O_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_release();
    test_mid_reset();
    test_abort();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
